// File: rtl/ws_systolic_stream.sv
// Weight-stationary M x N systolic matrix-vector engine with streaming activations.
// Weights stay resident; each accepted activation vector yields one de-skewed N-lane result.
module ws_systolic_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(M) + 1,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [N*DATA_WIDTH-1:0]   w_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [M*DATA_WIDTH-1:0]   a_data,
  input  logic                      a_last,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [N*ACC_WIDTH-1:0]    y_data,
  output logic                      y_last,
  output logic                      busy,
  output logic                      done
);

  localparam int L  = M + N;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

  state_t                 state;
  logic [CW-1:0]          row_cnt;
  logic [CW-1:0]          wr_row;
  logic                   in_batch;
  logic                   adv;
  logic                   w_fire;
  logic                   a_fire;
  logic                   y_fire;

  logic [DATA_WIDTH-1:0]  w_q     [M][N];
  logic [DATA_WIDTH-1:0]  skew_p0 [M][M];
  logic [DATA_WIDTH-1:0]  pe_a_in [M][N];
  logic [ACC_WIDTH-1:0]   pe_s_in [M][N];
  logic [DATA_WIDTH-1:0]  pe_a_p1 [M][N];
  logic [ACC_WIDTH-1:0]   pe_s_p1 [M][N];
  logic [ACC_WIDTH-1:0]   dsk_p2  [N][N];
  logic [ACC_WIDTH-1:0]   col_out [N];
  logic [L-1:0]           vld_p;
  logic [L-1:0]           last_p;

  // Full-precision product, extended to the accumulator width per operand signedness.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] w);
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic        [2*DATA_WIDTH-1:0] prod_u;
    prod_s = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
             $signed({{DATA_WIDTH{w[DATA_WIDTH-1]}}, w});
    prod_u = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, w};
    if (SIGNED) return ACC_WIDTH'(prod_s);
    else        return ACC_WIDTH'(prod_u);
  endfunction

  always_comb begin
    adv     = !(y_valid && !y_ready);
    w_ready = 1'b0;
    a_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE, LOAD: w_ready = 1'b1;
        READY: begin
          w_ready = !in_batch;
          a_ready = adv && !w_valid;
        end
        default: ;
      endcase
    end
    w_fire = w_valid && w_ready;
    a_fire = a_valid && a_ready;
    y_fire = y_valid && y_ready;
    wr_row = (state == LOAD) ? row_cnt : '0;
  end

  assign busy = (state == LOAD) || (state == DRAIN);
  assign done = y_fire && y_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      in_batch <= 1'b0;
    end else begin
      unique case (state)
        IDLE, READY: begin
          if (w_fire) begin
            row_cnt  <= CW'(1);
            in_batch <= 1'b0;
            state    <= (M == 1) ? READY : LOAD;
          end else if (a_fire) begin
            in_batch <= 1'b1;
            if (a_last) state <= DRAIN;
          end
        end
        LOAD: begin
          if (w_fire) begin
            if (row_cnt == CW'(M-1)) state <= READY;
            else                     row_cnt <= row_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (y_fire && y_last) begin
            state    <= READY;
            in_batch <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < M; r++)
        for (int n = 0; n < N; n++)
          w_q[r][n] <= '0;
    end else if (w_fire) begin
      for (int r = 0; r < M; r++)
        if (wr_row == CW'(r))
          for (int n = 0; n < N; n++)
            w_q[r][n] <= w_data[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // PE inputs: activations enter from the skew taps and move right; psums enter at 0 and move down.
  always_comb begin
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        pe_a_in[m][n] = skew_p0[m][m];
        if (n > 0) pe_a_in[m][n] = pe_a_p1[m][n-1];
        pe_s_in[m][n] = '0;
        if (m > 0) pe_s_in[m][n] = pe_s_p1[m-1][n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      col_out[n] = pe_s_p1[M-1][n];
      if (n < N-1) col_out[n] = dsk_p2[n][N-2-n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < M; m++)
        for (int d = 0; d < M; d++)
          skew_p0[m][d] <= '0;
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          pe_a_p1[m][n] <= '0;
          pe_s_p1[m][n] <= '0;
        end
      for (int n = 0; n < N; n++)
        for (int d = 0; d < N; d++)
          dsk_p2[n][d] <= '0;
      vld_p   <= '0;
      last_p  <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_data  <= '0;
    end else if (adv) begin
      // p0: input capture and per-row skew (row m delayed m stages)
      for (int m = 0; m < M; m++) begin
        skew_p0[m][0] <= a_fire ? a_data[m*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int d = 1; d < M; d++)
          if (d <= m) skew_p0[m][d] <= skew_p0[m][d-1];
      end
      // p1: processing elements
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          pe_a_p1[m][n] <= pe_a_in[m][n];
          pe_s_p1[m][n] <= pe_s_in[m][n] + mul_ext(pe_a_in[m][n], w_q[m][n]);
        end
      // p2: column de-skew (column n delayed N-1-n stages)
      for (int n = 0; n < N; n++) begin
        dsk_p2[n][0] <= pe_s_p1[M-1][n];
        for (int d = 1; d < N; d++)
          dsk_p2[n][d] <= dsk_p2[n][d-1];
      end
      // output register
      vld_p   <= {vld_p[L-2:0], a_fire};
      last_p  <= {last_p[L-2:0], a_fire && a_last};
      y_valid <= vld_p[L-1];
      y_last  <= last_p[L-1];
      for (int n = 0; n < N; n++)
        y_data[n*ACC_WIDTH +: ACC_WIDTH] <= col_out[n];
    end
  end

endmodule

// File: tb/tb_ws_systolic_stream.sv
// Scoreboard bench for ws_systolic_stream: signed instance for the main scenarios,
// unsigned instance for the zero-extension corner.
`timescale 1ns/1ps
module tb_ws_systolic_stream;
  localparam int DW  = 16;
  localparam int M   = 4;
  localparam int N   = 4;
  localparam int ACC = 2*DW + $clog2(M) + 1;
  localparam int YW  = N*ACC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_valid = 1'b0, w_ready;
  logic [N*DW-1:0] w_data = '0;
  logic          a_valid = 1'b0, a_ready, a_last = 1'b0;
  logic [M*DW-1:0] a_data = '0;
  logic          y_valid, y_ready = 1'b1, y_last, busy, done;
  logic [YW-1:0] y_data;

  logic          u_w_valid = 1'b0, u_w_ready;
  logic [N*DW-1:0] u_w_data = '0;
  logic          u_a_valid = 1'b0, u_a_ready, u_a_last = 1'b0;
  logic [M*DW-1:0] u_a_data = '0;
  logic          u_y_valid, u_y_ready = 1'b1, u_y_last, u_busy, u_done;
  logic [YW-1:0] u_y_data;

  ws_systolic_stream #(.DATA_WIDTH(DW), .M(M), .N(N), .ACC_WIDTH(ACC), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .busy(busy), .done(done));

  ws_systolic_stream #(.DATA_WIDTH(DW), .M(M), .N(N), .ACC_WIDTH(ACC), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .w_valid(u_w_valid), .w_ready(u_w_ready), .w_data(u_w_data),
    .a_valid(u_a_valid), .a_ready(u_a_ready), .a_data(u_a_data), .a_last(u_a_last),
    .y_valid(u_y_valid), .y_ready(u_y_ready), .y_data(u_y_data), .y_last(u_y_last),
    .busy(u_busy), .done(u_done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int yr_mode  = 0;
  logic [YW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [YW-1:0] u_exp_q[$];
  logic [DW-1:0] wm [M][N];

  task automatic chk_y(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bail(input string name);
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
    $fatal(1);
  endtask

  // Reference: y[n] = sum_m A[m]*W[m][n] in plain integer arithmetic, reduced mod 2^ACC.
  function automatic logic [YW-1:0] ref_y(input logic [M*DW-1:0] v,
                                          input logic [DW-1:0] w [M][N], input bit sgn);
    logic [YW-1:0] r;
    longint s, av, wv;
    logic [63:0] sv;
    r = '0;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int m = 0; m < M; m++) begin
        if (sgn) begin
          av = longint'($signed(v[m*DW +: DW]));
          wv = longint'($signed(w[m][n]));
        end else begin
          av = longint'({48'b0, v[m*DW +: DW]});
          wv = longint'({48'b0, w[m][n]});
        end
        s += av * wv;
      end
      sv = s;
      r[n*ACC +: ACC] = sv[ACC-1:0];
    end
    return r;
  endfunction

  task automatic load_w(input logic [DW-1:0] w [M][N], input int gap, input int start);
    int g;
    for (int r = start; r < M; r++) begin
      for (int n = 0; n < N; n++) w_data[n*DW +: DW] = w[r][n];
      w_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!w_ready) begin
        g++;
        if (g > 500) bail("w_ready_wait");
        @(negedge clk);
      end
      @(posedge clk); #1;
      w_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    wm = w;
  endtask

  task automatic send_vec(input logic [M*DW-1:0] v, input logic last);
    int g;
    a_data = v; a_last = last; a_valid = 1'b1; g = 0;
    @(negedge clk);
    while (!a_ready) begin
      g++;
      if (g > 500) bail("a_ready_wait");
      @(negedge clk);
    end
    exp_q.push_back(ref_y(v, wm, 1'b1));
    exp_last_q.push_back(last);
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin @(posedge clk); #1; g++; end
    chk_i(name, exp_q.size(), 0);
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk); #1;
  endtask

  function automatic logic [M*DW-1:0] rand_vec();
    logic [M*DW-1:0] v;
    for (int m = 0; m < M; m++) v[m*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // y_ready patterns: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      case (yr_mode)
        0: y_ready = 1'b1;
        1: begin y_ready = pat[3-ph]; ph = (ph + 1) % 4; end
        default: y_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor for the signed instance.
  initial begin
    logic          held_v, el;
    logic [YW-1:0] held_d, ed;
    logic          held_l;
    held_v = 1'b0; held_d = '0; held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v && y_valid) begin
          chk_y("hold_data", y_data, held_d);
          chk_b("hold_last", y_last, held_l);
        end
        if (y_valid && !y_ready) chk_b("stall_a_ready", a_ready, 1'b0);
        held_v = y_valid && !y_ready;
        held_d = y_data;
        held_l = y_last;
        if (y_valid && y_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got y_data %h with no result pending", y_data);
          end else begin
            ed = exp_q.pop_front();
            el = exp_last_q.pop_front();
            chk_y("y_data", y_data, ed);
            chk_b("y_last", y_last, el);
            chk_b("done", done, el);
          end
        end else begin
          chk_b("done_quiet", done, 1'b0);
        end
      end
    end
  end

  // Monitor for the unsigned instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && u_y_valid && u_y_ready) begin
        if (u_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL u_unexpected_output: got %h with no result pending", u_y_data);
        end else begin
          chk_y("u_y_data", u_y_data, u_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] wa [M][N];
    logic [DW-1:0] wb [M][N];
    logic [DW-1:0] uw [M][N];
    logic [M*DW-1:0] v;
    int lat, g;

    rst = 1'b1;
    @(negedge clk);
    chk_b("rst_w_ready", w_ready, 1'b0);
    chk_b("rst_a_ready", a_ready, 1'b0);
    chk_b("rst_y_valid", y_valid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_b("idle_busy", busy, 1'b0);
    chk_b("idle_w_ready", w_ready, 1'b1);
    chk_b("idle_a_ready", a_ready, 1'b0);
    chk_b("idle_done", done, 1'b0);
    chk_y("idle_y_data", y_data, '0);
    @(posedge clk); #1;

    // identity weights, single-vector batch, latency
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) wa[r][n] = (r == n) ? DW'(1) : DW'(0);
    load_w(wa, 0, 0);
    @(negedge clk);
    chk_b("loaded_busy", busy, 1'b0);
    @(posedge clk); #1;
    v = {16'd4, 16'd3, 16'd2, 16'd1};
    send_vec(v, 1'b1);
    lat = 0;
    while (!y_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk_i("latency", lat, M + N);
    wait_drain("identity_drain");
    @(negedge clk);
    chk_b("post_batch_busy", busy, 1'b0);
    chk_b("post_batch_w_ready", w_ready, 1'b1);
    @(posedge clk); #1;

    // all weights -1
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) wa[r][n] = 16'hFFFF;
    load_w(wa, 0, 0);
    v = {16'd5, 16'd4, 16'd3, 16'd2};
    send_vec(v, 1'b1);
    wait_drain("neg_drain");

    // 16 back-to-back vectors under a 1,0,0,1 y_ready pattern
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) wa[r][n] = DW'($urandom);
    load_w(wa, 0, 0);
    yr_mode = 1;
    for (int k = 0; k < 16; k++) send_vec(rand_vec(), k == 15);
    wait_drain("stream_drain");
    yr_mode = 0;

    // gapped load, then weight and activation offered together
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) begin
        wa[r][n] = DW'($urandom);
        wb[r][n] = DW'($urandom);
      end
    load_w(wa, 2, 0);
    send_vec(rand_vec(), 1'b1);
    wait_drain("gap_drain");
    for (int n = 0; n < N; n++) w_data[n*DW +: DW] = wb[0][n];
    a_data = rand_vec();
    w_valid = 1'b1; a_valid = 1'b1;
    @(negedge clk);
    chk_b("both_w_ready", w_ready, 1'b1);
    chk_b("both_a_ready", a_ready, 1'b0);
    @(posedge clk); #1;
    w_valid = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk_b("reload_busy", busy, 1'b1);
    @(posedge clk); #1;
    load_w(wb, 2, 1);
    yr_mode = 2;
    for (int k = 0; k < 6; k++) send_vec(rand_vec(), k == 5);
    wait_drain("reload_drain");
    yr_mode = 0;

    // reset mid-stream
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) wa[r][n] = DW'($urandom);
    load_w(wa, 0, 0);
    for (int k = 0; k < 3; k++) send_vec(rand_vec(), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    @(negedge clk);
    chk_b("midrst_w_ready", w_ready, 1'b0);
    chk_b("midrst_a_ready", a_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_b("after_rst_y_valid", y_valid, 1'b0);
    chk_b("after_rst_busy", busy, 1'b0);
    chk_b("after_rst_w_ready", w_ready, 1'b1);
    chk_b("after_rst_y_last", y_last, 1'b0);
    repeat (12) begin @(posedge clk); #1; end
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) wa[r][n] = DW'($urandom);
    load_w(wa, 0, 0);
    send_vec(rand_vec(), 1'b1);
    wait_drain("post_rst_drain");

    // unsigned instance: all operands 0xFFFF
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) uw[r][n] = 16'hFFFF;
    for (int r = 0; r < M; r++) begin
      u_w_data = {N{16'hFFFF}};
      u_w_valid = 1'b1;
      @(negedge clk);
      chk_b("u_w_ready", u_w_ready, 1'b1);
      @(posedge clk); #1;
    end
    u_w_valid = 1'b0;
    u_a_data = {M{16'hFFFF}};
    u_a_valid = 1'b1; u_a_last = 1'b1;
    @(negedge clk);
    chk_b("u_a_ready", u_a_ready, 1'b1);
    u_exp_q.push_back(ref_y(u_a_data, uw, 1'b0));
    @(posedge clk); #1;
    u_a_valid = 1'b0; u_a_last = 1'b0;
    g = 0;
    while (u_exp_q.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    chk_i("u_drain", u_exp_q.size(), 0);

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
